// File: rtl/stepper_ramp_gen.sv
// Single-axis step/direction generator with a trapezoidal speed profile.
// A start/busy/done handshake frames each move; abort finishes at the end of the current step.
module stepper_ramp_gen #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PULSE_W   = 1000,
   parameter int unsigned DIR_SETUP = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dir_in,
   input  logic [CNT_W-1:0] num_steps,
   input  logic [CNT_W-1:0] period_start,
   input  logic [CNT_W-1:0] period_min,
   input  logic [CNT_W-1:0] period_dec,
   output logic             step_out,
   output logic             dir_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_done,
   output logic [CNT_W-1:0] position
);

   localparam logic [CNT_W-1:0] One       = CNT_W'(1);
   localparam logic [CNT_W-1:0] PulseLen  = CNT_W'(PULSE_W);
   localparam logic [CNT_W-1:0] SetupLen  = CNT_W'(DIR_SETUP);
   localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(PULSE_W + 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulseHi,
      StPulseLo,
      StFinish
   } state_e;

   state_e stateQ, stateD;

   logic [CNT_W-1:0] cntQ, cntD;
   logic [CNT_W-1:0] numStepsQ, numStepsD;
   logic [CNT_W-1:0] periodStartQ, periodStartD;
   logic [CNT_W-1:0] periodMinQ, periodMinD;
   logic [CNT_W-1:0] periodDecQ, periodDecD;
   logic [CNT_W-1:0] curPeriodQ, curPeriodD;
   logic [CNT_W-1:0] accelCntQ, accelCntD;
   logic [CNT_W-1:0] stepsDoneQ, stepsDoneD;
   logic [CNT_W-1:0] positionQ, positionD;
   logic             abortPendQ, abortPendD;
   logic             dirQ, dirD;
   logic             stepQ, busyQ, doneQ;

   logic [CNT_W-1:0] tEff, lowLen, remaining, upPeriod, downPeriod;
   logic [CNT_W:0]   sumWide;
   logic             abortSeen;

   // Low phase fills the period, but never shorter than one cycle.
   assign tEff      = (curPeriodQ > MinPeriod) ? curPeriodQ : MinPeriod;
   assign lowLen    = tEff - PulseLen;
   assign remaining = numStepsQ - stepsDoneQ;

   // Widened sum so a huge decrement clamps to period_start instead of wrapping.
   assign sumWide    = {1'b0, curPeriodQ} + {1'b0, periodDecQ};
   assign upPeriod   = (sumWide > {1'b0, periodStartQ}) ? periodStartQ : sumWide[CNT_W-1:0];
   assign downPeriod = (periodDecQ >= (curPeriodQ - periodMinQ)) ? periodMinQ
                                                                 : (curPeriodQ - periodDecQ);
   assign abortSeen  = abortPendQ | abort;

   always_comb begin
      stateD       = stateQ;
      cntD         = cntQ;
      numStepsD    = numStepsQ;
      periodStartD = periodStartQ;
      periodMinD   = periodMinQ;
      periodDecD   = periodDecQ;
      curPeriodD   = curPeriodQ;
      accelCntD    = accelCntQ;
      stepsDoneD   = stepsDoneQ;
      positionD    = positionQ;
      abortPendD   = abortPendQ;
      dirD         = dirQ;

      case (stateQ)
         StIdle: begin
            if (start) begin
               numStepsD    = num_steps;
               periodStartD = period_start;
               periodMinD   = period_min;
               periodDecD   = period_dec;
               curPeriodD   = period_start;
               accelCntD    = '0;
               stepsDoneD   = '0;
               abortPendD   = 1'b0;
               dirD         = dir_in;
               cntD         = '0;
               stateD       = (num_steps == '0) ? StFinish : StSetup;
            end
         end

         StSetup: begin
            if (abort) begin
               stateD = StFinish;
            end else if (cntQ == SetupLen - One) begin
               cntD   = '0;
               stateD = StPulseHi;
            end else begin
               cntD = cntQ + One;
            end
         end

         StPulseHi: begin
            if (abort) begin
               abortPendD = 1'b1;
            end
            if (cntQ == PulseLen - One) begin
               cntD       = '0;
               stepsDoneD = stepsDoneQ + One;
               positionD  = dirQ ? (positionQ + One) : (positionQ - One);
               stateD     = StPulseLo;
            end else begin
               cntD = cntQ + One;
            end
         end

         StPulseLo: begin
            abortPendD = abortSeen;
            if (cntQ == lowLen - One) begin
               cntD = '0;
               if ((stepsDoneQ == numStepsQ) || abortSeen) begin
                  stateD = StFinish;
               end else begin
                  // Decel once the remaining steps match the steps spent accelerating.
                  if (remaining <= accelCntQ) begin
                     curPeriodD = upPeriod;
                     accelCntD  = (accelCntQ != '0) ? (accelCntQ - One) : '0;
                  end else if (curPeriodQ > periodMinQ) begin
                     curPeriodD = downPeriod;
                     accelCntD  = accelCntQ + One;
                  end
                  stateD = StPulseHi;
               end
            end else begin
               cntD = cntQ + One;
            end
         end

         StFinish: begin
            stateD = StIdle;
         end

         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ       <= StIdle;
         cntQ         <= '0;
         numStepsQ    <= '0;
         periodStartQ <= '0;
         periodMinQ   <= '0;
         periodDecQ   <= '0;
         curPeriodQ   <= '0;
         accelCntQ    <= '0;
         stepsDoneQ   <= '0;
         positionQ    <= '0;
         abortPendQ   <= 1'b0;
         dirQ         <= 1'b0;
         stepQ        <= 1'b0;
         busyQ        <= 1'b0;
         doneQ        <= 1'b0;
      end else begin
         stateQ       <= stateD;
         cntQ         <= cntD;
         numStepsQ    <= numStepsD;
         periodStartQ <= periodStartD;
         periodMinQ   <= periodMinD;
         periodDecQ   <= periodDecD;
         curPeriodQ   <= curPeriodD;
         accelCntQ    <= accelCntD;
         stepsDoneQ   <= stepsDoneD;
         positionQ    <= positionD;
         abortPendQ   <= abortPendD;
         dirQ         <= dirD;
         // Pin outputs are flopped from the next state so they are glitch-free.
         stepQ        <= (stateD == StPulseHi);
         busyQ        <= (stateD == StSetup) || (stateD == StPulseHi) || (stateD == StPulseLo);
         doneQ        <= (stateD == StFinish);
      end
   end

   assign step_out   = stepQ;
   assign dir_out    = dirQ;
   assign busy       = busyQ;
   assign done       = doneQ;
   assign steps_done = stepsDoneQ;
   assign position   = positionQ;

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Randomized bench for stepper_ramp_gen: a per-move timeline model predicts every
// step rising edge, the done cycle, step count and position.
module tb_stepper_ramp_gen;

   localparam int unsigned CW = 32;
   localparam int unsigned PW = 4;
   localparam int unsigned DS = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          dir_in;
   logic [CW-1:0] num_steps;
   logic [CW-1:0] period_start;
   logic [CW-1:0] period_min;
   logic [CW-1:0] period_dec;
   logic          step_out;
   logic          dir_out;
   logic          busy;
   logic          done;
   logic [CW-1:0] steps_done;
   logic [CW-1:0] position;

   int            cmpCnt = 0;
   int            errCnt = 0;
   int            cyc = 0;
   int            expRise[$];
   logic [CW-1:0] posModel = '0;

   stepper_ramp_gen #(
      .CNT_W     (CW),
      .PULSE_W   (PW),
      .DIR_SETUP (DS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .dir_in       (dir_in),
      .num_steps    (num_steps),
      .period_start (period_start),
      .period_min   (period_min),
      .period_dec   (period_dec),
      .step_out     (step_out),
      .dir_out      (dir_out),
      .busy         (busy),
      .done         (done),
      .steps_done   (steps_done),
      .position     (position)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkEq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      cmpCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
      end
   endtask

   // Timeline of one move: each step occupies max(period, PW+1) cycles from its rising edge;
   // an abort edge inside a step's span ends the move at the end of that span.
   task automatic buildModel(input logic [CW-1:0] n, input logic [CW-1:0] ps,
                             input logic [CW-1:0] pm, input logic [CW-1:0] dec,
                             input int k, input int abE, output int doneExp, output int nEff);
      longint cur, acc, t, te, fin, nn, lps, lpm, ldec;
      expRise.delete();
      nn   = longint'(n);
      lps  = longint'(ps);
      lpm  = longint'(pm);
      ldec = longint'(dec);
      cur  = lps;
      acc  = 0;
      nEff = 0;
      doneExp = k;
      if (nn == 0) return;
      if (abE > k && abE <= k + int'(DS)) begin
         doneExp = abE;
         return;
      end
      t = longint'(k) + longint'(DS);
      for (longint i = 1; i <= nn; i++) begin
         expRise.push_back(int'(t));
         te   = (cur > longint'(PW)) ? cur : longint'(PW) + 1;
         fin  = t + te;
         nEff = int'(i);
         if (i == nn || (longint'(abE) > t && longint'(abE) <= fin)) begin
            doneExp = int'(fin);
            return;
         end
         if (nn - i <= acc) begin
            cur = (cur + ldec > lps) ? lps : cur + ldec;
            if (acc > 0) acc--;
         end else if (cur > lpm) begin
            cur = (cur - ldec < lpm) ? lpm : cur - ldec;
            acc++;
         end
         t = fin;
      end
   endtask

   // abOff/stOff: 0 = none, >0 = edge offset from the start edge, <0 = random.
   task automatic runMove(input string tag, input logic d, input logic [CW-1:0] n,
                          input logic [CW-1:0] ps, input logic [CW-1:0] pm,
                          input logic [CW-1:0] dec, input int abOff, input int stOff);
      int   k, doneNom, doneExp, nEff, junk, abE, stE, dCnt, dAt;
      int   rises[$];
      int   falls[$];
      logic prev, bAtDone;
      @(negedge clk);
      dir_in       = d;
      num_steps    = n;
      period_start = ps;
      period_min   = pm;
      period_dec   = dec;
      start        = 1'b1;
      k = cyc + 1;
      buildModel(n, ps, pm, dec, k, 0, doneNom, junk);
      abE = 0;
      if (abOff > 0) abE = k + abOff;
      else if (abOff < 0) abE = k + int'($urandom_range(1, 32'(doneNom - k + 2)));
      buildModel(n, ps, pm, dec, k, abE, doneExp, nEff);
      stE = 0;
      if (stOff > 0) stE = k + stOff;
      else if (stOff < 0 && doneExp > k) stE = k + int'($urandom_range(1, 32'(doneExp - k)));
      prev    = 1'b0;
      dCnt    = 0;
      dAt     = -1;
      bAtDone = 1'b1;
      do begin
         @(negedge clk);
         if (step_out && !prev) rises.push_back(cyc);
         if (!step_out && prev) falls.push_back(cyc);
         prev = step_out;
         if (done) begin
            dCnt++;
            dAt     = cyc;
            bAtDone = busy;
         end
         if (cyc == k) begin
            dir_in       = ~d;
            num_steps    = $urandom;
            period_start = $urandom;
            period_min   = $urandom;
            period_dec   = $urandom;
         end
         start = (stE != 0 && stE == cyc + 1);
         abort = (abE != 0 && abE == cyc + 1);
      end while (cyc < doneExp + 2);
      start = 1'b0;
      abort = 1'b0;
      posModel = d ? posModel + CW'(nEff) : posModel - CW'(nEff);

      checkEq({tag, ":steps"}, CW'(rises.size()), CW'(expRise.size()));
      for (int i = 0; i < rises.size() && i < expRise.size(); i++)
         checkEq($sformatf("%s:rise%0d", tag, i), CW'(rises[i] - k), CW'(expRise[i] - k));
      checkEq({tag, ":falls"}, CW'(falls.size()), CW'(rises.size()));
      for (int i = 0; i < falls.size() && i < rises.size(); i++)
         checkEq($sformatf("%s:hiw%0d", tag, i), CW'(falls[i] - rises[i]), CW'(PW));
      checkEq({tag, ":donecnt"}, CW'(dCnt), 32'd1);
      checkEq({tag, ":doneat"}, CW'(dAt - k), CW'(doneExp - k));
      checkEq({tag, ":busy@done"}, CW'(bAtDone), 32'd0);
      checkEq({tag, ":steps_done"}, steps_done, CW'(nEff));
      checkEq({tag, ":position"}, position, posModel);
      checkEq({tag, ":dir_out"}, CW'(dir_out), CW'(d));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

   initial begin
      int k;
      logic [CW-1:0] dec;
      rst_n        = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      dir_in       = 1'b0;
      num_steps    = '0;
      period_start = '0;
      period_min   = '0;
      period_dec   = '0;
      #1 rst_n = 1'b0;
      #1;
      checkEq("reset:step_out", CW'(step_out), 32'd0);
      checkEq("reset:busy", CW'(busy), 32'd0);
      checkEq("reset:done", CW'(done), 32'd0);
      checkEq("reset:dir_out", CW'(dir_out), 32'd0);
      checkEq("reset:steps_done", steps_done, 32'd0);
      checkEq("reset:position", position, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      runMove("const3", 1'b1, 32'd3, 32'd10, 32'd10, 32'd0, 0, 0);
      runMove("ramp10", 1'b0, 32'd10, 32'd20, 32'd8, 32'd4, 0, 0);
      runMove("tri3", 1'b0, 32'd3, 32'd20, 32'd8, 32'd4, 0, 0);
      runMove("zero", 1'b1, 32'd0, 32'd10, 32'd10, 32'd0, 0, 0);
      // Second rise at k+12; abort lands two cycles into that pulse.
      runMove("abort2", 1'b1, 32'd10, 32'd10, 32'd10, 32'd0, 14, 5);
      runMove("abortsetup", 1'b0, 32'd5, 32'd10, 32'd10, 32'd0, 1, 0);
      runMove("clampdec", 1'b1, 32'd6, 32'd15, 32'd6, 32'hFFFF_FFF0, 0, 0);

      // Asynchronous reset in the middle of a high pulse.
      @(negedge clk);
      dir_in       = 1'b1;
      num_steps    = 32'd10;
      period_start = 32'd10;
      period_min   = 32'd10;
      period_dec   = 32'd0;
      start        = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < k + int'(DS) + 1) @(negedge clk);
      checkEq("rst:midhi", CW'(step_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkEq("rst:step_out", CW'(step_out), 32'd0);
      checkEq("rst:busy", CW'(busy), 32'd0);
      checkEq("rst:position", position, 32'd0);
      checkEq("rst:steps_done", steps_done, 32'd0);
      checkEq("rst:dir_out", CW'(dir_out), 32'd0);
      posModel = '0;
      @(negedge clk);
      rst_n = 1'b1;
      runMove("postrst", 1'b0, 32'd4, 32'd12, 32'd6, 32'd3, 0, 0);

      for (int i = 0; i < 40; i++) begin
         dec = CW'($urandom_range(0, 8));
         if ($urandom_range(0, 5) == 0) dec = 32'hFFFF_FFF0 + CW'($urandom_range(0, 15));
         runMove($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                 CW'($urandom_range(0, 12)), CW'($urandom_range(3, 30)),
                 CW'($urandom_range(1, 30)), dec,
                 ($urandom_range(0, 9) < 3) ? -1 : 0,
                 ($urandom_range(0, 1) == 1) ? -1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end

endmodule
